// File: rtl/pwm_controller.sv
// 16-channel PWM sequencer with shadow-buffered configuration and prescaled 8-bit period counter.
// Define PWM_SYNC_UPDATE_EN to defer shadow loads to period boundaries; otherwise loads follow cfg_valid.
module pwm_controller #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_valid,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out_bus,
  output logic        cfg_ack,
  output logic        period_start
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'd254;

  state_t      state;
  logic [15:0] div_cnt;
  logic [7:0]  pwm_cnt;
  logic [15:0] sh_out;
  logic [15:0] sh_pwm;
  logic [7:0]  sh_duty;
`ifdef PWM_SYNC_UPDATE_EN
  logic        pend;
`endif

  logic        running;
  logic        tick;
  logic        period_wrap;
  logic        pwm_hi;
  logic        load_sh;
  logic [15:0] chan_next;

  always_comb begin
    running     = (state == RUN) && enable;
    tick        = (state == RUN) && (div_cnt == DIV_LAST);
    period_wrap = tick && (pwm_cnt == CNT_LAST);
    pwm_hi      = (sh_duty == 8'hFF) || (pwm_cnt < sh_duty);
    chan_next   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      chan_next[i] = sh_out[i] & (~sh_pwm[i] | pwm_hi);
    end
  end

  // RUN entry always loads; a cfg_valid landing on the wrap loads now and stays pending.
  always_comb begin
    load_sh = 1'b0;
    if ((state == IDLE) && enable) begin
      load_sh = 1'b1;
`ifdef PWM_SYNC_UPDATE_EN
    end else if (running && period_wrap && (pend || cfg_valid)) begin
      load_sh = 1'b1;
`else
    end else if (cfg_valid) begin
      load_sh = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      pwm_cnt      <= '0;
      sh_out       <= '0;
      sh_pwm       <= '0;
      sh_duty      <= '0;
`ifdef PWM_SYNC_UPDATE_EN
      pend         <= 1'b0;
`endif
      out_bus      <= '0;
      cfg_ack      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (running) begin
        div_cnt <= tick ? '0 : div_cnt + 16'd1;
        if (tick) pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 8'd1;
        out_bus <= chan_next;
      end else begin
        div_cnt <= '0;
        pwm_cnt <= '0;
        out_bus <= '0;
      end

      period_start <= ((state == IDLE) && enable) || (running && period_wrap);
      cfg_ack      <= load_sh;

      if (load_sh) begin
        sh_out  <= {en_reg_out_15_8, en_reg_out_7_0};
        sh_pwm  <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
        sh_duty <= pwm_duty_cycle;
      end

`ifdef PWM_SYNC_UPDATE_EN
      if ((state == IDLE) && enable) pend <= 1'b0;
      else if (cfg_valid)            pend <= 1'b1;
      else if (load_sh)              pend <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/pwm_controller.md
# pwm_controller

Sequencing controller for the 16 output channels configured through the SPI register bank. It takes the five configuration bytes (output enables, PWM enables, duty cycle) as inputs and runs a prescaled 8-bit PWM period counter. It double-buffers the configuration into shadow registers so that changes land glitch-free on period boundaries, then drives the registered 16-bit output bus.

## Interface
- `CLK_DIV`, 3000: system clocks per PWM tick; legal range 1..65535. At 10 MHz this gives ≈13 Hz PWM.
- `clk`  in  1  system clock; every register is on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run control; low holds the block idle
- `cfg_valid`  in  1  single-cycle pulse: the register bank has completed a write
- `en_reg_out_7_0`, `en_reg_out_15_8`  in  8 each  per-channel output enable
- `en_reg_pwm_7_0`, `en_reg_pwm_15_8`  in  8 each  per-channel PWM-mode enable
- `pwm_duty_cycle`  in  8  shared duty value
- `out_bus`  out  16  channel outputs, registered
- `cfg_ack`  out  1  single-cycle pulse when the shadow registers load
- `period_start`  out  1  single-cycle pulse on the first cycle of each PWM period

## Operation
- **States.** The block has two states: IDLE and RUN.
  - IDLE → RUN when `enable`=1. On that edge the shadows load from the inputs, `cfg_ack` pulses, both counters clear, and `period_start` pulses.
  - RUN → IDLE when `enable`=0. Counters clear, `out_bus` goes to 0 on the next cycle, and the shadows keep their values.
- **Prescaler.** A 16-bit `div_cnt` counts 0..CLK_DIV-1 and then wraps. `tick`=1 on the cycle where `div_cnt`=CLK_DIV-1.
- **Period counter.** An 8-bit `pwm_cnt` advances on each `tick` through 0..254 and wraps to 0. The period is 255 ticks. `period_wrap` = `tick` AND `pwm_cnt`=254.
- **Per-channel output** (i = 0..15, all inputs taken from the shadow registers):
  - If `sh_out[i]`=0, the output is 0.
  - Otherwise, if `sh_pwm[i]`=0, the output is 1.
  - Otherwise the output is `pwm_hi`.
- **`pwm_hi` rule.** `pwm_hi` = 1 when `sh_duty`=8'hFF. Otherwise it is (`pwm_cnt` < `sh_duty`), an unsigned 8-bit compare. Consequences:
  - duty 0 gives a constant 0.
  - duty N gives N high ticks out of 255.
- **Pending flag.** `cfg_valid` sets `pend`.
  - The shadow update happens on `period_wrap` when `pend`=1. It copies all five inputs, clears `pend`, and pulses `cfg_ack`.
  - If `cfg_valid` and the update coincide, the current inputs are loaded and `pend` stays set, so the next wrap reloads (idempotent).
- **Updates in IDLE.** `cfg_valid` received in IDLE only sets `pend`. That pending load is consumed by the IDLE→RUN load.
- **Reset.** `rst` asserted at any time, including mid-period, clears everything immediately.

## Timing
- **Reset values.** `out_bus`=16'h0000, `cfg_ack`=0, `period_start`=0. State is IDLE. `div_cnt`, `pwm_cnt`, `pend` and all shadows are 0.
- **Output latency.** `out_bus` is registered and reflects the `pwm_cnt` and shadow values of the previous cycle, a latency of 1 clk.
- **`period_start`** asserts the cycle after `period_wrap`, and on RUN entry.
- **`cfg_ack`** asserts the cycle the shadows load. New values appear on `out_bus` one cycle later.
- **Worst-case application latency** from `cfg_valid` is 255·CLK_DIV+1 clks.
- **CLK_DIV=1.** `tick` is constantly 1 and the period is 255 clks.

## Configuration
- **`PWM_SYNC_UPDATE_EN`.**
  - **Defined:** shadow loading is deferred to `period_wrap` as described in Operation.
  - **Undefined:** the shadows load on the cycle after `cfg_valid`, with `cfg_ack` pulsing on that same cycle. `pend` is unused and the counters are unaffected. This mode accepts mid-period glitches in exchange for minimum latency.

## Test plan
- **Reset:** assert `rst` mid-RUN with duty=0x80 → `out_bus`=0, `cfg_ack`=0 and `period_start`=0 within the same cycle; after release, IDLE until `enable`=1.
- **Static on:** CLK_DIV=2, en_out=0x0001, en_pwm=0, enable=1 → `out_bus`=16'h0001 from cycle 2 after enable; `period_start` pulses every 510 clks.
- **PWM duty:** en_out=en_pwm=0x8001, duty=0x40, CLK_DIV=2 → bits 0 and 15 are high for 128 clks and low for 382 clks of each 510-clk period. duty=0xFF → constantly 1. duty=0x00 → constantly 0.
- **Deferred update:** at `pwm_cnt`=10, change duty 0x40→0xC0 and pulse `cfg_valid` → the current period keeps 64 high ticks. `cfg_ack` pulses exactly once, at the wrap. The next period has 192 high ticks.
- **Coincident events:** pulse `cfg_valid` on the `period_wrap` cycle → `cfg_ack` at this wrap and again at the following wrap. Also, disable and re-enable with a write pending → load on RUN entry, and no ack at the next wrap.
- **Macro off:** build without `PWM_SYNC_UPDATE_EN` and pulse `cfg_valid` mid-period → `cfg_ack` on the next cycle; `out_bus` reflects the new duty one cycle after that.
